// File: rtl/adexp_pkg.sv
// Shared types and constants for the AdEx spike encoder: event layout,
// tag-byte bit positions and the serializer state encoding.
package adexp_pkg;

  localparam int TS_W       = 16;
  localparam int TAG_MARK   = 7;
  localparam int TAG_SPIKE  = 6;
  localparam int TAG_WRAP   = 5;
  localparam int TAG_DROP_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TAG  = 2'd1,
    HI   = 2'd2,
    LO   = 2'd3
  } enc_state_t;

  typedef struct packed {
    logic            is_spike;
    logic            is_wrap;
    logic [TS_W-1:0] ts;
  } spike_evt_t;

endpackage

// File: rtl/adexp_event_fifo.sv
// Small synchronous FIFO for timestamped spike events; a push into a full
// FIFO is accepted when a pop happens in the same cycle.
module adexp_event_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 18
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           wr_data,
  input  logic                   pop,
  output logic [W-1:0]           rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full    = (cnt_q == FULL_CNT);
  assign empty   = (cnt_q == '0);
  assign level   = cnt_q;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read behind the count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/adexp_spike_encoder.sv
// Timestamps AdEx spike pulses, queues them and streams each one as a
// 3-byte frame (tag, ts high, ts low) over an 8-bit valid/ready bus.
module adexp_spike_encoder
  import adexp_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DROP_W = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en_i,
  input  logic                   tick_i,
  input  logic                   spike_i,
  output logic [7:0]             out_data_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [$clog2(DEPTH):0] fifo_level_o,
  output logic                   overflow_o,
  output logic [1:0]             dbg_state_o
);

  // Output bus: a byte moves when out_valid_o && out_ready_i at posedge clk;
  // once raised, out_valid_o and out_data_o hold until that handshake.

  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  enc_state_t        state_q, state_d;
  spike_evt_t        frame_q, frame_d;
  spike_evt_t        evt, fifo_rd;
  logic [TS_W-1:0]   ts_q, ts_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic [DROP_W-1:0] snap_q, snap_d;
  logic              ovf_q, ovf_d;
  logic              tick_en, push, pop, drop, full, empty;
  logic [7:0]        tag;

  always_comb begin
    tick_en      = tick_i & en_i;
    evt.is_spike = spike_i & en_i;
    evt.is_wrap  = tick_en & (ts_q == '1);
    evt.ts       = ts_q;
    push         = evt.is_spike | evt.is_wrap;
    pop          = (state_q == IDLE) & ~empty;
    drop         = push & full & ~pop;
    ts_d         = tick_en ? ts_q + TS_W'(1) : ts_q;
    ovf_d        = ovf_q | drop;
  end

  adexp_event_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(spike_evt_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (evt),
    .pop     (pop),
    .rd_data (fifo_rd),
    .full    (full),
    .empty   (empty),
    .level   (fifo_level_o)
  );

  // The drop count restarts whenever it is snapshotted into a frame.
  always_comb begin
    drop_d = drop_q;
    if (pop) begin
      drop_d = drop ? DROP_W'(1) : '0;
    end else if (drop && (drop_q != DROP_MAX)) begin
      drop_d = drop_q + DROP_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    snap_d  = snap_q;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          state_d = TAG;
          frame_d = fifo_rd;
          snap_d  = drop_q;
        end
      end
      TAG:     if (out_ready_i) state_d = HI;
      HI:      if (out_ready_i) state_d = LO;
      LO:      if (out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tag                   = '0;
    tag[TAG_MARK]         = 1'b1;
    tag[TAG_SPIKE]        = frame_q.is_spike;
    tag[TAG_WRAP]         = frame_q.is_wrap;
    tag[TAG_DROP_W-1:0]   = TAG_DROP_W'(snap_q);
    out_valid_o           = (state_q != IDLE);
    case (state_q)
      TAG:     out_data_o = tag;
      HI:      out_data_o = frame_q.ts[15:8];
      LO:      out_data_o = frame_q.ts[7:0];
      default: out_data_o = 8'h00;
    endcase
  end

  assign overflow_o  = ovf_q;
  assign dbg_state_o = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      frame_q <= '0;
      ts_q    <= '0;
      drop_q  <= '0;
      snap_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      ts_q    <= ts_d;
      drop_q  <= drop_d;
      snap_q  <= snap_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_adexp_spike_encoder.sv
// Self-checking bench for adexp_spike_encoder: expected frame bytes are
// queued as stimulus is driven and compared as the bus hands them over.
module tb_adexp_spike_encoder;
  import adexp_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en_i = 1'b1;
  logic       tick_i = 1'b0;
  logic       spike_i = 1'b0;
  logic       out_ready_i = 1'b1;
  logic [7:0] out_data_o;
  logic       out_valid_o;
  logic [$clog2(DEPTH):0] fifo_level_o;
  logic       overflow_o;
  logic [1:0] dbg_state_o;

  logic [7:0]  exp_q[$];
  logic [15:0] model_ts = 16'h0000;
  int          n_cmp = 0;
  int          n_err = 0;

  adexp_spike_encoder #(.DEPTH(DEPTH), .DROP_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .en_i         (en_i),
    .tick_i       (tick_i),
    .spike_i      (spike_i),
    .out_data_o   (out_data_o),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .fifo_level_o (fifo_level_o),
    .overflow_o   (overflow_o),
    .dbg_state_o  (dbg_state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic sp, input logic wr, input logic [4:0] drp,
                            input logic [15:0] t);
    exp_q.push_back({1'b1, sp, wr, drp});
    exp_q.push_back(t[15:8]);
    exp_q.push_back(t[7:0]);
  endtask

  // One cycle of tick/spike stimulus; queues the expected frame when asked.
  task automatic drive_cycle(input logic tk, input logic sp, input logic model_on);
    logic is_sp, is_wr;
    is_sp = sp & en_i;
    is_wr = tk & en_i & (model_ts == 16'hFFFF);
    if (model_on && (is_sp || is_wr)) push_frame(is_sp, is_wr, 5'd0, model_ts);
    if (tk && en_i) model_ts = model_ts + 16'd1;
    tick_i  = tk;
    spike_i = sp;
    step();
    tick_i  = 1'b0;
    spike_i = 1'b0;
  endtask

  task automatic drain(input int budget);
    int i;
    i = 0;
    while ((exp_q.size() != 0 || out_valid_o) && i < budget) begin
      step();
      i++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    chk("drain_idle", 32'(out_valid_o), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_ts = 16'h0000;
    exp_q.delete();
  endtask

  // scoreboard: compare every accepted byte against the expected queue
  always @(negedge clk) begin
    if (!rst && out_valid_o && out_ready_i) begin
      if (exp_q.size() == 0) begin
        chk("extra_byte_queue", 32'd0, 32'd1);
      end else begin
        chk("frame_byte", 32'(out_data_o), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    logic found;
    step();
    step();
    chk("rst_valid", 32'(out_valid_o), 32'd0);
    chk("rst_data", 32'(out_data_o), 32'h00);
    chk("rst_level", 32'(fifo_level_o), 32'd0);
    chk("rst_ovf", 32'(overflow_o), 32'd0);
    rst = 1'b0;

    // single spike at ts=5
    repeat (5) drive_cycle(1'b1, 1'b0, 1'b1);
    drive_cycle(1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk("lat_n1_valid", 32'(out_valid_o), 32'd0);
    @(negedge clk);
    chk("lat_n2_valid", 32'(out_valid_o), 32'd1);
    chk("lat_n2_data", 32'(out_data_o), 32'hC0);
    drain(20);

    // backpressure
    out_ready_i = 1'b0;
    drive_cycle(1'b0, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      chk("stall_valid", 32'(out_valid_o), 32'd1);
      chk("stall_data", 32'(out_data_o), 32'hC0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    out_ready_i = 1'b1;
    drain(20);

    // wrap with spike, then ts must read 0
    while (model_ts != 16'hFFFF) drive_cycle(1'b1, 1'b0, 1'b1);
    drive_cycle(1'b1, 1'b1, 1'b1);
    drive_cycle(1'b0, 1'b1, 1'b1);
    drain(40);

    // wrap without spike: timestamp preloaded to 0xFFFF
    @(negedge clk);
    force dut.ts_q = 16'hFFFF;
    @(negedge clk);
    release dut.ts_q;
    @(posedge clk);
    #1;
    model_ts = 16'hFFFF;
    drive_cycle(1'b1, 1'b0, 1'b1);
    drive_cycle(1'b0, 1'b1, 1'b1);
    drain(40);

    // overflow: 7 spikes on consecutive ticks while stalled
    do_reset();
    out_ready_i = 1'b0;
    for (int k = 0; k < 7; k++) begin
      drive_cycle(1'b1, 1'b1, 1'b0);
      if (k == 4) begin
        chk("ovf_level_after5", 32'(fifo_level_o), 32'd4);
        chk("ovf_flag_after5", 32'(overflow_o), 32'd0);
      end
      if (k == 5) chk("ovf_flag_after6", 32'(overflow_o), 32'd1);
    end
    push_frame(1'b1, 1'b0, 5'd0, 16'd0);
    push_frame(1'b1, 1'b0, 5'd2, 16'd1);
    for (int k = 2; k < 5; k++) push_frame(1'b1, 1'b0, 5'd0, 16'(k));
    out_ready_i = 1'b1;
    drain(60);
    chk("ovf_sticky", 32'(overflow_o), 32'd1);

    // saturation: 40 drops while stalled
    out_ready_i = 1'b0;
    repeat (45) drive_cycle(1'b0, 1'b1, 1'b0);
    chk("sat_level", 32'(fifo_level_o), 32'd4);
    push_frame(1'b1, 1'b0, 5'd0, 16'd7);
    push_frame(1'b1, 1'b0, 5'd31, 16'd7);
    repeat (3) push_frame(1'b1, 1'b0, 5'd0, 16'd7);
    out_ready_i = 1'b1;
    drain(60);

    // enable low: no frames, timestamp frozen
    en_i = 1'b0;
    repeat (6) drive_cycle(1'b1, 1'b1, 1'b1);
    repeat (3) step();
    chk("en_level", 32'(fifo_level_o), 32'd0);
    chk("en_valid", 32'(out_valid_o), 32'd0);
    en_i = 1'b1;
    drive_cycle(1'b0, 1'b1, 1'b1);
    drain(20);

    // reset during the HI byte
    drive_cycle(1'b0, 1'b1, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (dbg_state_o == HI) found = 1'b1;
    end
    chk("reach_hi", 32'(found), 32'd1);
    rst = 1'b1;
    step();
    chk("midrst_valid", 32'(out_valid_o), 32'd0);
    chk("midrst_level", 32'(fifo_level_o), 32'd0);
    chk("midrst_pending", 32'(exp_q.size()), 32'd2);
    rst = 1'b0;
    exp_q.delete();
    model_ts = 16'h0000;
    repeat (10) step();
    chk("post_rst_valid", 32'(out_valid_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
